// File: rtl/key_click_decode_pkg.sv
// Shared definitions for the key click decoder: event codes, FSM states and
// the default double-click window for 50 MHz boards.
package key_click_decode_pkg;

    typedef enum logic [1:0] {
        EVT_NONE   = 2'd0,
        EVT_SINGLE = 2'd1,
        EVT_DOUBLE = 2'd2,
        EVT_LONG   = 2'd3
    } evtCode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT2  = 2'd1,
        PEND_L = 2'd2
    } fsmState_t;

    localparam int          CNT_W         = 24;
    localparam logic [23:0] T_DBL_DEFAULT = 24'd15_000_000;

endpackage

// File: rtl/key_click_decode_if.sv
// Event port of the click decoder: FWFT valid/ready stream plus fill level
// and sticky overflow flag.
interface key_click_decode_if #(
    parameter int FIFO_AW = 2
);
    logic             EVT_VALID;
    logic [1:0]       EVT_CODE;
    logic             EVT_READY;
    logic [FIFO_AW:0] EVT_COUNT;
    logic             OVERFLOW;

    modport master (
        output EVT_VALID,
        output EVT_CODE,
        output EVT_COUNT,
        output OVERFLOW,
        input  EVT_READY
    );

    modport slave (
        input  EVT_VALID,
        input  EVT_CODE,
        input  EVT_COUNT,
        input  OVERFLOW,
        output EVT_READY
    );
endinterface

// File: rtl/key_click_decode_evt_fifo.sv
// Small first-word-fall-through FIFO for 2-bit key events, with fill count
// and a sticky flag set whenever a push is refused.
module key_evt_fifo #(
    parameter int FIFO_AW = 2
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             push,
    input  logic [1:0]       pushData,
    input  logic             ready,
    output logic             valid,
    output logic [1:0]       headData,
    output logic             full,
    output logic [FIFO_AW:0] count,
    output logic             overflow
);
    localparam int DEPTH = 2 ** FIFO_AW;

    logic [1:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wrPtr;
    logic [FIFO_AW-1:0] rdPtr;
    logic               popEn;
    logic               pushEn;

    assign valid    = (count != '0);
    assign full     = (count == (FIFO_AW + 1)'(DEPTH));
    assign popEn    = valid && ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign pushEn   = push && (!full || popEn);
    assign headData = mem[rdPtr];

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 2'd0;
            end
        end else begin
            if (pushEn) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (popEn) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (push && !pushEn) begin
                overflow <= 1'b1;
            end
            case ({pushEn, popEn})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/key_click_decode.sv
// Turns short/long click pulses into SINGLE/DOUBLE/LONG events and queues
// them in a small FIFO for consumers that drain at their own pace.
module key_click_decode
    import key_click_decode_pkg::*;
#(
    parameter logic [23:0] T_DBL   = T_DBL_DEFAULT,
    parameter int          FIFO_AW = 2
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                S_CLICK,
    input  logic                L_CLICK,
    key_click_decode_if.master  evt
);
    fsmState_t        state;
    fsmState_t        stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic             windowDone;
    logic             pushNext;
    logic [1:0]       codeNext;
    logic             pushP0;
    logic [1:0]       codeP0;
    logic             unusedFull;

    assign windowDone = (cnt == T_DBL - 24'd1);

    // Stage p0: FSM state, window counter and the registered push request.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state  <= IDLE;
            cnt    <= '0;
            pushP0 <= 1'b0;
        end else begin
            state  <= stateNext;
            cnt    <= cntNext;
            pushP0 <= pushNext;
        end
    end

    always_ff @(posedge CLOCK) begin
        codeP0 <= codeNext;
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        case (state)
            IDLE: begin
                if (!L_CLICK && S_CLICK) begin
                    cntNext   = '0;
                    stateNext = WAIT2;
                end
            end
            WAIT2: begin
                if (L_CLICK) begin
                    stateNext = PEND_L;
                end else if (S_CLICK) begin
                    stateNext = IDLE;
                end else if (windowDone) begin
                    cntNext   = '0;
                    stateNext = IDLE;
                end else begin
                    cntNext = cnt + 24'd1;
                end
            end
            PEND_L:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // A long press inside the window first flushes the pending click as SINGLE.
    always_comb begin
        pushNext = 1'b0;
        codeNext = EVT_NONE;
        case (state)
            IDLE: begin
                if (L_CLICK) begin
                    pushNext = 1'b1;
                    codeNext = EVT_LONG;
                end
            end
            WAIT2: begin
                if (L_CLICK || windowDone) begin
                    pushNext = 1'b1;
                    codeNext = EVT_SINGLE;
                end else if (S_CLICK) begin
                    pushNext = 1'b1;
                    codeNext = EVT_DOUBLE;
                end
                if (!L_CLICK && S_CLICK) begin
                    codeNext = EVT_DOUBLE;
                end
            end
            PEND_L: begin
                pushNext = 1'b1;
                codeNext = EVT_LONG;
            end
            default: begin
                pushNext = 1'b0;
                codeNext = EVT_NONE;
            end
        endcase
    end

    // Stage p1: event queue; full is left for consumers wired elsewhere.
    key_evt_fifo #(
        .FIFO_AW (FIFO_AW)
    ) uFifo (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .push     (pushP0),
        .pushData (codeP0),
        .ready    (evt.EVT_READY),
        .valid    (evt.EVT_VALID),
        .headData (evt.EVT_CODE),
        .full     (unusedFull),
        .count    (evt.EVT_COUNT),
        .overflow (evt.OVERFLOW)
    );

endmodule
